// File: rtl/i2s_frame_fifo_pkg.sv
// Shared types for the I2S frame FIFO: default sample width, FSM states,
// and the stereo frame layout (left in the upper half, right in the lower).
package i2s_pkg;

    localparam int AUDIO_DW = 16;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [AUDIO_DW-1:0] left;
        logic [AUDIO_DW-1:0] right;
    } frame_t;

endpackage

// File: rtl/i2s_frame_fifo_if.sv
// Core-side handshake plus serializer-side sample bus for i2s_frame_fifo.
// master = the core/serializer side driving frames and lrclk,
// slave  = the FIFO itself.
interface i2s_frame_fifo_if #(
    parameter int AUDIO_DW   = i2s_pkg::AUDIO_DW,
    parameter int DEPTH_LOG2 = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [AUDIO_DW-1:0] in_left;
    logic [AUDIO_DW-1:0] in_right;
    logic                lrclk;
    logic [AUDIO_DW-1:0] left_chan;
    logic [AUDIO_DW-1:0] right_chan;
    logic [DEPTH_LOG2:0] level;
    logic                underrun;

    modport master (
        output in_valid, in_left, in_right, lrclk,
        input  in_ready, left_chan, right_chan, level, underrun
    );

    modport slave (
        input  in_valid, in_left, in_right, lrclk,
        output in_ready, left_chan, right_chan, level, underrun
    );
endinterface

// File: rtl/i2s_fifo_mem.sv
// Simple dual-port frame storage: synchronous write, asynchronous read so
// the head entry is always visible and a pop can register it in one cycle.
module i2s_fifo_mem #(
    parameter int DW = 2 * i2s_pkg::AUDIO_DW,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];

    // Write port; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/i2s_frame_fifo.sv
// Stereo frame FIFO feeding the I2S serializer. Frames are pushed by the
// core over valid/ready and one frame is popped per lrclk rising edge, so
// the new sample is stable long before the serializer latches it on the
// falling edge. After reset or an underrun the FIFO re-primes (FILL) until
// PRIME_LVL frames are stored.
// Build option I2S_FIFO_UNDERRUN_MUTE_EN: when defined, an underrun zeroes
// the outputs until the next real pop; otherwise the last frame repeats.
module i2s_frame_fifo
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW   = i2s_pkg::AUDIO_DW,
    parameter int DEPTH_LOG2 = 3,
    parameter int PRIME_LVL  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    i2s_frame_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW    = 2 * AUDIO_DW;

    typedef logic [DEPTH_LOG2:0] lvl_t;
    localparam lvl_t FULL_LVL  = lvl_t'(DEPTH);
    localparam lvl_t PRIME_THR = lvl_t'(PRIME_LVL);

    state_t                state_q;
    logic                  lrclk_q;
    lvl_t                  level_q, level_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [AUDIO_DW-1:0]   left_q, right_q;
    logic                  underrun_q;
    logic [FW-1:0]         rd_data;
    logic                  in_ready, push, pop, lr_rise;

    // Ready looks at the pre-pop level, so a full FIFO never takes a frame.
    assign in_ready = (level_q != FULL_LVL);
    assign push     = bus.in_valid & in_ready;
    assign lr_rise  = bus.lrclk & ~lrclk_q;
    assign pop      = (state_q == RUN) & lr_rise & (level_q != '0);
    assign level_d  = level_q + lvl_t'(push) - lvl_t'(pop);

    i2s_fifo_mem #(.DW(FW), .AW(DEPTH_LOG2)) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.in_left, bus.in_right}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Pointers, occupancy and the lrclk edge history; lrclk_q resets high so
    // an lrclk already high after reset is not seen as a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            lrclk_q  <= 1'b1;
        end else begin
            lrclk_q <= bus.lrclk;
            level_q <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FILL/RUN control with registered sample outputs and underrun pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FILL;
            left_q     <= '0;
            right_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (level_q >= PRIME_THR) state_q <= RUN;
                end
                RUN: begin
                    if (lr_rise) begin
                        if (level_q != '0) begin
                            {left_q, right_q} <= rd_data;
                        end else begin
                            underrun_q <= 1'b1;
                            state_q    <= FILL;
`ifdef I2S_FIFO_UNDERRUN_MUTE_EN
                            left_q     <= '0;
                            right_q    <= '0;
`else
                            left_q     <= left_q;
                            right_q    <= right_q;
`endif
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.level      = level_q;
    assign bus.left_chan  = left_q;
    assign bus.right_chan = right_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_i2s_frame_fifo.sv
// Bench for i2s_frame_fifo: directed scenarios followed by random push and
// lrclk activity, all compared each cycle against a queue-based model.
module tb_i2s_frame_fifo;
    import i2s_pkg::*;

    localparam int DEPTH = 8;
    localparam int PRIME = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    i2s_frame_fifo_if #(.AUDIO_DW(16), .DEPTH_LOG2(3)) bus();

    i2s_frame_fifo #(.AUDIO_DW(16), .DEPTH_LOG2(3), .PRIME_LVL(PRIME)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;

    // Reference model: a frame queue, a primed/running flag and the frame
    // last handed to the serializer.
    frame_t mq[$];
    bit     m_run, m_prev_lr, m_unr, m_push;
    frame_t m_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_run     = 1'b0;
        m_prev_lr = 1'b1;
        m_unr     = 1'b0;
        m_push    = 1'b0;
        m_out     = '0;
    endtask

    // One clock: advance the model on the rising edge from the inputs the
    // bench drove, then compare every output on the falling edge.
    task automatic cyc();
        bit rise, nrun, unr_n;
        @(posedge clk);
        if (!reset_n) begin
            m_reset();
        end else begin
            rise      = bus.lrclk && !m_prev_lr;
            m_prev_lr = bus.lrclk;
            m_push    = bus.in_valid && (mq.size() != DEPTH);
            nrun      = m_run;
            unr_n     = 1'b0;
            if (m_run) begin
                if (rise) begin
                    if (mq.size() != 0) begin
                        m_out = mq.pop_front();
                    end else begin
                        unr_n = 1'b1;
                        nrun  = 1'b0;
`ifdef I2S_FIFO_UNDERRUN_MUTE_EN
                        m_out = '0;
`endif
                    end
                end
            end else if (mq.size() >= PRIME) begin
                nrun = 1'b1;
            end
            if (m_push) mq.push_back({bus.in_left, bus.in_right});
            m_run = nrun;
            m_unr = unr_n;
        end
        @(negedge clk);
        chk("level",    32'(bus.level),      mq.size());
        chk("in_ready", 32'(bus.in_ready),   32'(mq.size() != DEPTH));
        chk("left",     32'(bus.left_chan),  32'(m_out.left));
        chk("right",    32'(bus.right_chan), 32'(m_out.right));
        chk("underrun", 32'(bus.underrun),   32'(m_unr));
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_left  = l;
        bus.in_right = r;
        do begin
            cyc();
            n++;
        end while (!m_push && n < 50);
        if (!m_push) chk("push_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic lr_pulse(input int half);
        bus.lrclk = 1'b0;
        repeat (half) cyc();
        bus.lrclk = 1'b1;
        repeat (half) cyc();
    endtask

    logic [15:0] last_l, last_r;
    int          half_cnt, pv;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_left  = '0;
        bus.in_right = '0;
        bus.lrclk    = 1'b0;
        m_reset();
        #1 reset_n = 1'b0;
        repeat (3) cyc();
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_left",  32'(bus.left_chan), 32'd0);
        chk("rst_unr",   32'(bus.underrun), 32'd0);
        reset_n = 1'b1;
        cyc();

        // Prime with four frames while lrclk is idle.
        for (int k = 0; k < 4; k++)
            push_frame(16'h1111 * 16'(k + 1), 16'hA001 + 16'(k));
        repeat (2) cyc();
        chk("prime_level", 32'(bus.level), 32'd4);
        chk("prime_left",  32'(bus.left_chan), 32'd0);
        chk("prime_ready", 32'(bus.in_ready), 32'd1);

        // lrclk period 64: one frame per rising edge, latency 1.
        for (int k = 0; k < 4; k++) begin
            bus.lrclk = 1'b1;
            cyc();
            chk("pop_left",  32'(bus.left_chan),  32'(16'h1111 * 16'(k + 1)));
            chk("pop_right", 32'(bus.right_chan), 32'(16'hA001 + 16'(k)));
            chk("pop_level", 32'(bus.level), 32'(3 - k));
            repeat (31) cyc();
            bus.lrclk = 1'b0;
            repeat (32) cyc();
        end

        // Fill to the top with no edges; the ninth frame must wait.
        for (int k = 0; k < 8; k++)
            push_frame(16'h2000 + 16'(k), 16'hB000 + 16'(k));
        bus.in_valid = 1'b1;
        bus.in_left  = 16'h2008;
        bus.in_right = 16'hB008;
        repeat (2) cyc();
        chk("full_level", 32'(bus.level), 32'd8);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        bus.lrclk = 1'b1;
        cyc();
        chk("bp_pop_left", 32'(bus.left_chan), 32'h2000);
        cyc();
        bus.in_valid = 1'b0;
        chk("bp_level", 32'(bus.level), 32'd8);

        // Drain all eight, then one edge too many.
        repeat (8) lr_pulse(4);
        chk("drain_left",  32'(bus.left_chan), 32'h2008);
        chk("drain_level", 32'(bus.level), 32'd0);
        bus.lrclk = 1'b0;
        repeat (4) cyc();
        bus.lrclk = 1'b1;
        cyc();
        chk("unr_pulse", 32'(bus.underrun), 32'd1);
`ifdef I2S_FIFO_UNDERRUN_MUTE_EN
        chk("unr_left", 32'(bus.left_chan), 32'd0);
`else
        chk("unr_left", 32'(bus.left_chan), 32'h2008);
`endif
        cyc();
        chk("unr_clear", 32'(bus.underrun), 32'd0);

        // Re-prime: edges below PRIME_LVL must not pop.
        for (int k = 0; k < 3; k++)
            push_frame(16'h3000 + 16'(k), 16'hC000 + 16'(k));
        repeat (2) lr_pulse(4);
        chk("fill_level", 32'(bus.level), 32'd3);
        chk("fill_unr",   32'(bus.underrun), 32'd0);
        push_frame(16'h3003, 16'hC003);
        repeat (2) cyc();
        bus.lrclk = 1'b0;
        cyc();
        bus.lrclk = 1'b1;
        cyc();
        chk("reprime_left", 32'(bus.left_chan), 32'h3000);
        push_frame(16'h3004, 16'hC004);
        push_frame(16'h3005, 16'hC005);
        chk("pre_rst_level", 32'(bus.level), 32'd5);

        // Asynchronous reset mid-cycle, no clock edge needed.
        #2 reset_n = 1'b0;
        #1;
        chk("arst_level", 32'(bus.level), 32'd0);
        chk("arst_left",  32'(bus.left_chan), 32'd0);
        chk("arst_right", 32'(bus.right_chan), 32'd0);
        bus.lrclk = 1'b1;
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("post_rst_unr", 32'(bus.underrun), 32'd0);
        for (int k = 0; k < 4; k++)
            push_frame(16'h4000 + 16'(k), 16'hD000 + 16'(k));
        repeat (4) cyc();
        chk("hi_lr_level", 32'(bus.level), 32'd4);
        chk("hi_lr_left",  32'(bus.left_chan), 32'd0);

        // Random traffic against the model.
        half_cnt = 1;
        pv       = 70;
        for (int c = 0; c < 40000; c++) begin
            if (c % 2000 == 0) pv = int'($urandom_range(30, 95));
            if (--half_cnt == 0) begin
                bus.lrclk = ~bus.lrclk;
                half_cnt  = int'($urandom_range(1, 3));
            end
            if (!(bus.in_valid && !m_push)) begin
                bus.in_valid = (int'($urandom_range(0, 99)) < pv);
                last_l       = 16'($urandom);
                last_r       = 16'($urandom);
                bus.in_left  = last_l;
                bus.in_right = last_r;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
